alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: select codes, carry validity, FSM states.
package alu_pkg;

   localparam logic [2:0] SEL_ADD    = 3'b000;
   localparam logic [2:0] SEL_ASHL   = 3'b001;
   localparam logic [2:0] SEL_XNOR   = 3'b010;
   localparam logic [2:0] SEL_DIV2   = 3'b011;
   localparam logic [2:0] SEL_PASS2  = 3'b100;
   localparam logic [2:0] SEL_PASS1  = 3'b101;
   localparam logic [2:0] SEL_COMP2S = 3'b110;
   localparam logic [2:0] SEL_ROUND  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // The ALU carry-out is only meaningful for add and the two shifts.
   function automatic logic sel_has_carry(input logic [2:0] sel);
      return (sel == SEL_ADD) || (sel == SEL_ASHL) || (sel == SEL_DIV2);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic any_valid_o
);

   always_comb begin
      any_valid_o = valid0_i | valid1_i;
      grant_o     = valid1_i & (~valid0_i | ~last_grant_i);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Operands are registered toward the ALU and its result is captured one cycle later.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [SEL_W-1:0]  req0_sel,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [SEL_W-1:0]  req1_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_co,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_co,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic                last_grant_q;
   logic                grant, any_valid;
   logic                accept, complete;
   logic [DATA_W-1:0]   alu_op1_q, alu_op2_q, rsp_data_q;
   logic [SEL_W-1:0]    alu_sel_q;
   logic                rsp_valid_q, rsp_id_q, rsp_co_q;
   logic [CNT_W-1:0]    op_count_q;

   rr_arb2 u_rr_arb2 (
      .valid0_i     (req0_valid),
      .valid1_i     (req1_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_valid_o  (any_valid)
   );

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            // rsp_valid is always set in RESP, so rsp_ready alone completes the handshake.
            if (rsp_ready) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req0_ready = accept & ~grant;
   assign req1_ready = accept & grant;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         alu_op1_q    <= '0;
         alu_op2_q    <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_co_q     <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_op1_q    <= grant ? req1_op1 : req0_op1;
            alu_op2_q    <= grant ? req1_op2 : req0_op2;
            alu_sel_q    <= grant ? req1_sel : req0_sel;
            rsp_id_q     <= grant;
            last_grant_q <= grant;
         end
         if (state_q == EXEC) begin
            rsp_data_q  <= alu_out;
            rsp_co_q    <= alu_co & sel_has_carry(alu_sel_q);
            rsp_valid_q <= 1'b1;
         end
         if (complete) begin
            rsp_valid_q <= 1'b0;
            if (op_count_q != {CNT_W{1'b1}}) begin
               op_count_q <= op_count_q + CntOne;
            end
         end
      end
   end

   assign alu_op1   = alu_op1_q;
   assign alu_op2   = alu_op2_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_co    = rsp_co_q;
   assign op_count  = op_count_q;

endmodule
